regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Sequencer directly upstream of the single-port regfile (addr / d_in / we_ / d_out).
- Accepts one pipeline request per handshake: up to one write plus two operand reads (A, B). Serialises them onto the regfile port and returns both operands on a response handshake.
- Lets the decode/execute stages see a 2R1W register file without changing the regfile macro.

Parameters:
- ADDR_W, 5, regfile address width.
- DATA_W, 32, regfile data width.
- DATA_D, 32, number of implemented registers (DATA_D <= 2**ADDR_W).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- rd_a_addr  in  ADDR_W  operand A register.
- rd_b_addr  in  ADDR_W  operand B register.
- wr_en  in  1  request carries a write.
- wr_addr  in  ADDR_W  write register.
- wr_data  in  DATA_W  write value.
- rsp_valid  out  1  operands valid.
- rsp_ready  in  1  consumer takes operands.
- rd_a_data  out  DATA_W  operand A.
- rd_b_data  out  DATA_W  operand B.
- rf_addr  out  ADDR_W  to regfile addr.
- rf_d_in  out  DATA_W  to regfile d_in.
- rf_we_  out  1  to regfile we_, active low.
- rf_d_out  in  DATA_W  from regfile d_out (combinational read of rf_addr).

Behaviour:
- Interface (already decided): one clock (clk); reset is synchronous and active-high (reset).
- Reset values: req_ready=1, rsp_valid=0, rd_a_data=0, rd_b_data=0, rf_addr=0, rf_d_in=0, rf_we_=1 (disabled). FSM goes to IDLE.
- FSM states: IDLE, WRITE, READ_A, READ_B, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch all request fields.
  - Next state is WRITE if wr_en, else READ_A.
- WRITE:
  - rf_addr=wr_addr, rf_d_in=wr_data, rf_we_=0 for exactly one cycle.
  - Next state READ_A.
- READ_A:
  - rf_addr=rd_a_addr, rf_we_=1.
  - rf_d_out is captured into rd_a_data at the closing edge.
  - Next state READ_B.
- READ_B: same as READ_A for operand B into rd_b_data; next state RESP.
- RESP:
  - rsp_valid=1. rd_a_data and rd_b_data are held stable until rsp_ready.
  - On rsp_ready, next state IDLE and rsp_valid drops the next cycle.
- Ordering: the write always precedes the reads. A read of wr_addr in the same request returns wr_data (write-then-read semantics).
- Latency (accept edge to first rsp_valid cycle): 4 cycles with wr_en, 3 without.
- Throughput: one request per (latency + 1) cycles minimum. No pipelining; req_ready=0 outside IDLE.
- Regfile port outside WRITE, READ_A and READ_B: rf_addr=0, rf_d_in=0, rf_we_=1. rf_we_ is never low outside WRITE.
- Out-of-range address (>= DATA_D): the write is suppressed (rf_we_ stays 1 in WRITE) and the read returns 0. State sequence and latency are unchanged.
- Request inputs are ignored unless IDLE and req_valid=1.
- Reset mid-operation: the in-flight request is dropped, any pending write is abandoned (rf_we_=1 on the next cycle), and all outputs take their reset values.
- rsp_ready asserted while rsp_valid=0 has no effect.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - A write to address 0 still occupies the WRITE state, but rf_we_ stays 1.
  - Reads of address 0 return 0 regardless of rf_d_out.
  - Latency is unchanged.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared header regfile.h holds:
  - ADDR_W, DATA_W, DATA_D defaults.
  - HIGH/LOW and ENABLE_/DISABLE_ levels.
  - New FSM state encodings: 3-bit, IDLE=0, WRITE=1, READ_A=2, READ_B=3, RESP=4.
- No sub-module. FSM, request latch and operand capture registers are inline in one module.

Test Plan:
- Reset held 2 cycles, then released -> req_ready=1, rsp_valid=0, rf_we_=1, rf_addr=0.
- Write-only then read: write r5=0x0000_00A5 (rd_a=5, rd_b=0); regfile preloaded with r0=0x11 -> exactly one rf_we_=0 cycle with rf_addr=5; rsp_valid 4 cycles after accept; rd_a_data=0xA5, rd_b_data=0x11.
- Read-only request rd_a=3, rd_b=7 with r3=0x33, r7=0x77 -> no rf_we_ pulse; rsp_valid 3 cycles after accept; data 0x33/0x77.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid stays 1, data stable, req_ready=0; one cycle after rsp_ready=1, req_ready=1.
- Reset asserted during WRITE -> next cycle rf_we_=1, rsp_valid=0; a subsequent read of that register returns its old value.
- With REGFILE_ZERO_REG_EN: write 0xFFFF_FFFF to r0, then read rd_a=0 -> no rf_we_ pulse, rd_a_data=0. Without the macro, rd_a_data=0xFFFF_FFFF.

Source files
------------

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared defaults, signal levels and FSM encodings for regfile_access_ctrl.
// Holds ADDR_W/DATA_W/DATA_D defaults, HIGH/LOW, ENABLE_/DISABLE_, state_t.
package regfile_access_ctrl_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DATA_D = 32;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Regfile write enable is active low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_READ_A = 3'd2,
    ST_READ_B = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/regfile_access_ctrl.sv
// Serialises one write + two reads onto a single-port regfile (2R1W view).
// Ports: clk/reset, req_* request handshake, rsp_* operand handshake,
//   rf_addr/rf_d_in/rf_we_/rf_d_out to the regfile macro.
// Option: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_access_ctrl
  import regfile_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int DATA_D = RF_DATA_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rd_a_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rd_a_data,
  output logic [DATA_W-1:0] rd_b_data,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_d_in,
  output logic              rf_we_,
  input  logic [DATA_W-1:0] rf_d_out
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DATA_D);

  state_t state;
  state_t state_n;

  logic              accept;
  logic [ADDR_W-1:0] a_q;
  logic [ADDR_W-1:0] b_q;
  logic              wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  // An address is live when it maps to a real, writable register.
  function automatic logic live(input logic [ADDR_W-1:0] a);
    logic ok;
    ok = ({1'b0, a} < LIMIT);
`ifdef REGFILE_ZERO_REG_EN
    ok = ok && (a != '0);
`endif
    return ok;
  endfunction

  assign req_ready = (state == ST_IDLE) ? HIGH : LOW;
  assign rsp_valid = (state == ST_RESP) ? HIGH : LOW;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_n = wr_en ? ST_WRITE : ST_READ_A;
      end
      ST_WRITE:  state_n = ST_READ_A;
      ST_READ_A: state_n = ST_READ_B;
      ST_READ_B: state_n = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) state_n = ST_IDLE;
      end
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      wen_q   <= LOW;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      a_q     <= rd_a_addr;
      b_q     <= rd_b_addr;
      wen_q   <= wr_en;
      waddr_q <= wr_addr;
      wdata_q <= wr_data;
    end
  end

  // Operands are captured at the edge closing each read cycle and
  // then held untouched through RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
    end else begin
      if (state == ST_READ_A)
        rd_a_data <= live(a_q) ? rf_d_out : '0;
      if (state == ST_READ_B)
        rd_b_data <= live(b_q) ? rf_d_out : '0;
    end
  end

  // Reset gates the write enable so a write caught mid-flight by
  // reset never lands in the regfile.
  always_comb begin
    rf_addr = '0;
    rf_d_in = '0;
    rf_we_  = DISABLE_;
    unique case (state)
      ST_WRITE: begin
        rf_addr = waddr_q;
        rf_d_in = wdata_q;
        if (wen_q && live(waddr_q) && !reset)
          rf_we_ = ENABLE_;
      end
      ST_READ_A: rf_addr = a_q;
      ST_READ_B: rf_addr = b_q;
      default: begin
        rf_addr = '0;
        rf_d_in = '0;
        rf_we_  = DISABLE_;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed self-checking bench for regfile_access_ctrl.
// Contains a behavioural single-port regfile with combinational read.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  rd_a_addr;
  logic [4:0]  rd_b_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rd_a_data;
  logic [31:0] rd_b_data;
  logic [4:0]  rf_addr;
  logic [31:0] rf_d_in;
  logic        rf_we_;
  logic [31:0] rf_d_out;

  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] mem [32];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_access_ctrl #(
    .ADDR_W(5),
    .DATA_W(32),
    .DATA_D(24)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .rd_a_addr(rd_a_addr),
    .rd_b_addr(rd_b_addr),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rd_a_data(rd_a_data),
    .rd_b_data(rd_b_data),
    .rf_addr(rf_addr),
    .rf_d_in(rf_d_in),
    .rf_we_(rf_we_),
    .rf_d_out(rf_d_out)
  );

  assign rf_d_out = mem[rf_addr];

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (rf_we_ == 1'b0) mem[rf_addr] <= rf_d_in;
  end

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issues one request and watches it until rsp_valid (bounded).
  task automatic send(input logic [4:0] a, input logic [4:0] b,
                      input logic wen, input logic [4:0] wa,
                      input logic [31:0] wd, output int lat,
                      output int pulses, output logic [4:0] paddr);
    @(negedge clk);
    req_valid = 1'b1; rd_a_addr = a; rd_b_addr = b;
    wr_en = wen; wr_addr = wa; wr_data = wd;
    lat = 0; pulses = 0; paddr = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0; rd_a_addr = 5'h1f; rd_b_addr = 5'h1e;
        wr_en = 1'b1; wr_addr = 5'h1d; wr_data = '1;
      end
      if (rf_we_ === 1'b0) begin pulses++; paddr = rf_addr; end
      if (rsp_valid === 1'b1) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); end
    total++; if (rf_we_ !== 1'b1) begin bad++; $display("FAIL rst_rf_we_ got %b want 1", rf_we_); end
    total++; if (rf_addr !== 5'd0) begin bad++; $display("FAIL rst_rf_addr got %0d want 0", rf_addr); end
    total++; if (rd_a_data !== 32'd0) begin bad++; $display("FAIL rst_rd_a got %h want 0", rd_a_data); end
  endtask

  task automatic test_write_read;
    int lat; int p; logic [4:0] pa; logic [31:0] exp_b;
`ifdef REGFILE_ZERO_REG_EN
    exp_b = 32'h0;
`else
    exp_b = 32'h11;
`endif
    preload(5'd0, 32'h11);
    send(5'd5, 5'd0, 1'b1, 5'd5, 32'h0000_00A5, lat, p, pa);
    total++; if (lat != 4) begin bad++; $display("FAIL wr_latency got %0d want 4", lat); end
    total++; if (p != 1) begin bad++; $display("FAIL wr_pulses got %0d want 1", p); end
    total++; if (pa !== 5'd5) begin bad++; $display("FAIL wr_addr got %0d want 5", pa); end
    total++; if (rd_a_data !== 32'hA5) begin bad++; $display("FAIL wr_rd_a got %h want a5", rd_a_data); end
    total++; if (rd_b_data !== exp_b) begin bad++; $display("FAIL wr_rd_b got %h want %h", rd_b_data, exp_b); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_drop got %b want 0", rsp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_read_only;
    int lat; int p; logic [4:0] pa;
    preload(5'd3, 32'h33);
    preload(5'd7, 32'h77);
    rsp_ready = 1'b1;
    send(5'd3, 5'd7, 1'b0, 5'd3, 32'hDEAD_BEEF, lat, p, pa);
    total++; if (lat != 3) begin bad++; $display("FAIL rd_latency got %0d want 3", lat); end
    total++; if (p != 0) begin bad++; $display("FAIL rd_pulses got %0d want 0", p); end
    total++; if (rd_a_data !== 32'h33) begin bad++; $display("FAIL rd_a got %h want 33", rd_a_data); end
    total++; if (rd_b_data !== 32'h77) begin bad++; $display("FAIL rd_b got %h want 77", rd_b_data); end
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rd_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_backpressure;
    int lat; int p; logic [4:0] pa;
    send(5'd7, 5'd3, 1'b0, 5'd0, 32'h0, lat, p, pa);
    total++; if (lat != 3) begin bad++; $display("FAIL bp_latency got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got %b want 1", i, rsp_valid); end
      total++; if (rd_a_data !== 32'h77) begin bad++; $display("FAIL bp_rd_a[%0d] got %h want 77", i, rd_a_data); end
      total++; if (rd_b_data !== 32'h33) begin bad++; $display("FAIL bp_rd_b[%0d] got %h want 33", i, rd_b_data); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_release got %b want 1", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_rsp_drop got %b want 0", rsp_valid); end
  endtask

  task automatic test_reset_mid_write;
    int lat; int p; logic [4:0] pa;
    preload(5'd9, 32'h99);
    @(negedge clk);
    req_valid = 1'b1; rd_a_addr = 5'd9; rd_b_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hDEAD;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++; if (rf_we_ !== 1'b1) begin bad++; $display("FAIL mr_rf_we_ got %b want 1", rf_we_); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mr_rsp_valid got %b want 0", rsp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mr_req_ready got %b want 1", req_ready); end
    total++; if (rd_a_data !== 32'd0) begin bad++; $display("FAIL mr_rd_a_clr got %h want 0", rd_a_data); end
    reset = 1'b0;
    rsp_ready = 1'b1;
    send(5'd9, 5'd3, 1'b0, 5'd0, 32'h0, lat, p, pa);
    total++; if (rd_a_data !== 32'h99) begin bad++; $display("FAIL mr_old_val got %h want 99", rd_a_data); end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_zero_reg;
    int lat; int p; logic [4:0] pa; int exp_p; logic [31:0] exp_a;
`ifdef REGFILE_ZERO_REG_EN
    exp_p = 0; exp_a = 32'h0;
`else
    exp_p = 1; exp_a = 32'hFFFF_FFFF;
`endif
    rsp_ready = 1'b1;
    send(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, lat, p, pa);
    total++; if (lat != 4) begin bad++; $display("FAIL z_latency got %0d want 4", lat); end
    total++; if (p != exp_p) begin bad++; $display("FAIL z_pulses got %0d want %0d", p, exp_p); end
    total++; if (rd_a_data !== exp_a) begin bad++; $display("FAIL z_rd_a got %h want %h", rd_a_data, exp_a); end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_out_of_range;
    int lat; int p; logic [4:0] pa;
    preload(5'd25, 32'h2525);
    rsp_ready = 1'b1;
    send(5'd25, 5'd26, 1'b1, 5'd26, 32'hBEEF, lat, p, pa);
    total++; if (lat != 4) begin bad++; $display("FAIL oor_latency got %0d want 4", lat); end
    total++; if (p != 0) begin bad++; $display("FAIL oor_pulses got %0d want 0", p); end
    total++; if (rd_a_data !== 32'd0) begin bad++; $display("FAIL oor_rd_a got %h want 0", rd_a_data); end
    total++; if (rd_b_data !== 32'd0) begin bad++; $display("FAIL oor_rd_b got %h want 0", rd_b_data); end
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    rd_a_addr = '0; rd_b_addr = '0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    test_reset;
    test_write_read;
    test_read_only;
    test_backpressure;
    test_reset_mid_write;
    test_zero_reg;
    test_out_of_range;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
